mem_bus_initiator: RTL and testbench

- Processor-side initiator for the tagged memory bus (`proc2mem_*` / `mem2proc_*`).
- Arbitrates load/store requests from two clients: port 0 = data side, port 1 = instruction fetch.
- Drives one command at a time and holds it until memory accepts it with a nonzero response tag.
- Tracks outstanding loads by tag and routes each tagged data return to the owning client.

---
 rtl/mem_bus_initiator_pkg.sv | 48 ++++
 rtl/mem_bus_initiator_tag_table.sv | 105 ++++++++++
 rtl/mem_bus_initiator.sv | 137 +++++++++++++
 tb/tb_mem_bus_initiator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_initiator_pkg.sv
// mem_bus_initiator_pkg: shared types for the tagged memory bus initiator.
//   BUS_COMMAND   - bus command encoding driven on proc2mem_command
//   MEM_SIZE      - access size encoding
//   MEM_TAG_ENTRY - one outstanding-load record {valid, drop, owner, addr}
//   mem_cmd_t     - latched client request held while a command is issued
// Optional feature macro: MEM_BUS_SQUASH_EN adds the drop bit to MEM_TAG_ENTRY.
`ifndef XLEN
`define XLEN 32
`endif

package mem_bus_initiator_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'h0,
    MEM_HALF   = 2'h1,
    MEM_WORD   = 2'h2,
    MEM_DOUBLE = 2'h3
  } MEM_SIZE;

  typedef struct packed {
    logic             valid;
`ifdef MEM_BUS_SQUASH_EN
    logic             drop;
`endif
    logic             owner;
    logic [`XLEN-1:0] addr;
  } MEM_TAG_ENTRY;

  typedef struct packed {
    logic             store;
    logic             owner;
    logic [`XLEN-1:0] addr;
    logic [63:0]      data;
    MEM_SIZE          size;
  } mem_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/mem_bus_initiator_tag_table.sv
// mem_tag_table: outstanding-load table indexed by bus tag (1..NUM_TAGS).
//   alloc_*          - load accepted by memory: record owner/addr under alloc_tag
//   ret_tag          - tagged data return; 0 = no return this cycle
//   rsp_valid/addr   - registered one-cycle delivery to the owning client
//   outstanding_cnt  - registered count of valid entries
//   protocol_error   - sticky: stray return, tag reuse or out-of-range tag
// Optional feature macro: MEM_BUS_SQUASH_EN adds alloc_drop/squash inputs;
// entries marked drop are retired silently when their data comes back.
`ifndef XLEN
`define XLEN 32
`endif

module mem_tag_table
  import mem_bus_initiator_pkg::*;
#(
  parameter int NUM_TAGS = 15,
  parameter int TAG_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_owner,
  input  logic [`XLEN-1:0] alloc_addr,
`ifdef MEM_BUS_SQUASH_EN
  input  logic             alloc_drop,
  input  logic             squash,
`endif
  input  logic [TAG_W-1:0] ret_tag,
  output logic [1:0]       rsp_valid,
  output logic [`XLEN-1:0] rsp_addr,
  output logic [TAG_W:0]   outstanding_cnt,
  output logic             protocol_error
);

  MEM_TAG_ENTRY     tbl_q [NUM_TAGS:1];
  MEM_TAG_ENTRY     tbl_d [NUM_TAGS:1];
  MEM_TAG_ENTRY     ret_ent;
  logic             ret_in, alloc_in, ret_hit, ret_deliver, err_d;
  logic [TAG_W:0]   cnt_d;

  assign ret_in   = (ret_tag != '0) && (int'(ret_tag) <= NUM_TAGS);
  assign alloc_in = (alloc_tag != '0) && (int'(alloc_tag) <= NUM_TAGS);

  // Ordering inside one cycle: retire the return first, then allocate, then
  // squash, so a tag returned and re-accepted in the same cycle ends valid.
  always_comb begin
    tbl_d       = tbl_q;
    ret_ent     = '0;
    ret_hit     = 1'b0;
    ret_deliver = 1'b0;
    err_d       = 1'b0;
    cnt_d       = '0;

    if (ret_tag != '0) begin
      if (ret_in) ret_ent = tbl_q[ret_tag];
      ret_hit = ret_ent.valid;
      err_d   = !ret_ent.valid;
      if (ret_in && ret_hit) tbl_d[ret_tag] = '0;
    end
`ifdef MEM_BUS_SQUASH_EN
    ret_deliver = ret_hit && !ret_ent.drop;
`else
    ret_deliver = ret_hit;
`endif

    if (alloc_en) begin
      if (alloc_in) begin
        if (tbl_d[alloc_tag].valid) err_d = 1'b1;
        tbl_d[alloc_tag].valid = 1'b1;
        tbl_d[alloc_tag].owner = alloc_owner;
        tbl_d[alloc_tag].addr  = alloc_addr;
`ifdef MEM_BUS_SQUASH_EN
        tbl_d[alloc_tag].drop  = alloc_drop;
`endif
      end else begin
        err_d = 1'b1;
      end
    end

    for (int i = 1; i <= NUM_TAGS; i++) begin
`ifdef MEM_BUS_SQUASH_EN
      if (squash && tbl_d[i].valid && tbl_d[i].owner) tbl_d[i].drop = 1'b1;
`endif
      cnt_d = cnt_d + {{TAG_W{1'b0}}, tbl_d[i].valid};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= NUM_TAGS; i++) tbl_q[i] <= '0;
      rsp_valid       <= '0;
      rsp_addr        <= '0;
      outstanding_cnt <= '0;
      protocol_error  <= 1'b0;
    end else begin
      tbl_q           <= tbl_d;
      rsp_valid       <= ret_deliver ? (ret_ent.owner ? 2'b10 : 2'b01) : 2'b00;
      if (ret_hit) rsp_addr <= ret_ent.addr;
      outstanding_cnt <= cnt_d;
      if (err_d) protocol_error <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: two-client initiator for the tagged memory bus.
//   cl_req_*      - client requests (0 = data side, 1 = instruction fetch)
//   cl_req_ack    - one-cycle pulse after memory accepted that client's command
//   cl_rsp_*      - one-cycle load data delivery, routed by tag owner
//   proc2mem_*    - bus command, held stable until a nonzero response tag
//   mem2proc_*    - accept tag, return data and return tag (0 = none)
//   outstanding_cnt / protocol_error - table occupancy and sticky error
// Optional feature macro: MEM_BUS_SQUASH_EN adds squash_if, which silently
// drops all pending and in-flight client-1 loads.
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int NUM_TAGS = 15,
  parameter int TAG_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            cl_req_valid,
  input  logic [1:0]            cl_req_store,
  input  logic [1:0][`XLEN-1:0] cl_req_addr,
  input  logic [1:0][63:0]      cl_req_data,
  input  MEM_SIZE [1:0]         cl_req_size,
  output logic [1:0]            cl_req_ack,
  output logic [1:0]            cl_rsp_valid,
  output logic [63:0]           cl_rsp_data,
  output logic [`XLEN-1:0]      cl_rsp_addr,
  output BUS_COMMAND            proc2mem_command,
  output logic [`XLEN-1:0]      proc2mem_addr,
  output logic [63:0]           proc2mem_data,
  output MEM_SIZE               proc2mem_size,
  input  logic [TAG_W-1:0]      mem2proc_response,
  input  logic [63:0]           mem2proc_data,
  input  logic [TAG_W-1:0]      mem2proc_tag,
`ifdef MEM_BUS_SQUASH_EN
  input  logic                  squash_if,
`endif
  output logic [TAG_W:0]        outstanding_cnt,
  output logic                  protocol_error
);

  fsm_state_e state_q, state_d;
  mem_cmd_t   cmd_q;
  logic       ptr_q;
  logic [1:0] elig;
  logic       win, accept;

  // A client still sees its ack during the IDLE cycle after accept and has
  // not yet dropped valid; masking it prevents re-issuing the same request.
  assign elig   = cl_req_valid & ~cl_req_ack;
  assign win    = ptr_q ? elig[1] : ~elig[0];
  assign accept = (state_q == ISSUE) && (mem2proc_response != '0);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|elig) state_d = ISSUE;
      ISSUE:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs: only driven while issuing so the bus idles between commands
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = MEM_BYTE;
    if (state_q == ISSUE) begin
      if (cmd_q.store) proc2mem_command = BUS_STORE;
      else             proc2mem_command = BUS_LOAD;
      proc2mem_addr = cmd_q.addr;
      proc2mem_data = cmd_q.data;
      proc2mem_size = cmd_q.size;
    end
  end

  // Command register, round-robin pointer, ack pulse, return data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q       <= '0;
      ptr_q       <= 1'b0;
      cl_req_ack  <= '0;
      cl_rsp_data <= '0;
    end else begin
      if (state_q == IDLE && |elig)
        cmd_q <= '{store: cl_req_store[win], owner: win, addr: cl_req_addr[win],
                   data: cl_req_data[win], size: cl_req_size[win]};
      if (accept) ptr_q <= ~cmd_q.owner;
      cl_req_ack <= accept ? (cmd_q.owner ? 2'b10 : 2'b01) : 2'b00;
      if (mem2proc_tag != '0) cl_rsp_data <= mem2proc_data;
    end
  end

`ifdef MEM_BUS_SQUASH_EN
  // Remembers a squash that hit a client-1 command before memory accepted it,
  // so its entry is born already dropped.
  logic cmd_drop_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cmd_drop_q <= 1'b0;
    else if (state_q == IDLE && |elig)
      cmd_drop_q <= squash_if & win;
    else if (state_q == ISSUE && squash_if && cmd_q.owner)
      cmd_drop_q <= 1'b1;
  end
`endif

  mem_tag_table #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_tag_table (
    .clock           (clock),
    .reset           (reset),
    .alloc_en        (accept & ~cmd_q.store),
    .alloc_tag       (mem2proc_response),
    .alloc_owner     (cmd_q.owner),
    .alloc_addr      (cmd_q.addr),
`ifdef MEM_BUS_SQUASH_EN
    .alloc_drop      (cmd_drop_q),
    .squash          (squash_if),
`endif
    .ret_tag         (mem2proc_tag),
    .rsp_valid       (cl_rsp_valid),
    .rsp_addr        (cl_rsp_addr),
    .outstanding_cnt (outstanding_cnt),
    .protocol_error  (protocol_error)
  );

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator: self-checking bench for mem_bus_initiator.
// Table-driven single transactions, then hand sequences for round-robin,
// same-cycle return/re-accept, stray tags and mid-issue reset. Load data
// deliveries are checked against a scoreboard queue filled at return time.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_initiator;
  import mem_bus_initiator_pkg::*;

  localparam int TAG_W = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [1:0]            cl_req_valid, cl_req_store;
  logic [1:0][`XLEN-1:0] cl_req_addr;
  logic [1:0][63:0]      cl_req_data;
  MEM_SIZE [1:0]         cl_req_size;
  logic [1:0]            cl_req_ack, cl_rsp_valid;
  logic [63:0]           cl_rsp_data;
  logic [`XLEN-1:0]      cl_rsp_addr;
  BUS_COMMAND            proc2mem_command;
  logic [`XLEN-1:0]      proc2mem_addr;
  logic [63:0]           proc2mem_data;
  MEM_SIZE               proc2mem_size;
  logic [TAG_W-1:0]      mem2proc_response, mem2proc_tag;
  logic [63:0]           mem2proc_data;
  logic [TAG_W:0]        outstanding_cnt;
  logic                  protocol_error;

  mem_bus_initiator #(.NUM_TAGS(15), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .cl_req_valid(cl_req_valid), .cl_req_store(cl_req_store),
    .cl_req_addr(cl_req_addr), .cl_req_data(cl_req_data), .cl_req_size(cl_req_size),
    .cl_req_ack(cl_req_ack), .cl_rsp_valid(cl_rsp_valid),
    .cl_rsp_data(cl_rsp_data), .cl_rsp_addr(cl_rsp_addr),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .outstanding_cnt(outstanding_cnt), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic             owner;
    logic [63:0]      data;
    logic [`XLEN-1:0] addr;
  } rsp_t;
  rsp_t sb_q[$];

  // Reference table model
  bit               m_v   [16];
  bit               m_own [16];
  logic [`XLEN-1:0] m_addr[16];
  int               exp_cnt = 0;
  bit               exp_err = 1'b0;
  logic             last_owner = 1'b0;

  typedef struct {
    logic             owner;
    logic             store;
    logic [`XLEN-1:0] addr;
    logic [63:0]      data;
    MEM_SIZE          size;
    int               delay;
    logic [3:0]       tag;
    logic             ret;
    logic [63:0]      rdata;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [1:0] oh(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: every delivered response must match the queue head
  always @(negedge clock) begin : mon
    rsp_t e;
    if (reset && cl_rsp_valid != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", {62'd0, cl_rsp_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_owner", {62'd0, cl_rsp_valid}, {62'd0, oh(e.owner)});
        check("sb_data", cl_rsp_data, e.data);
        check("sb_addr", {32'd0, cl_rsp_addr}, {32'd0, e.addr});
      end
    end
  end

  task automatic wait_cmd(input BUS_COMMAND ec);
    bit ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (proc2mem_command != BUS_NONE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("cmd_timeout", {62'd0, proc2mem_command}, {62'd0, ec});
  endtask

  task automatic model_alloc(input logic [3:0] tg, input logic o, input logic [`XLEN-1:0] a);
    if (m_v[tg]) exp_err = 1'b1;
    else         exp_cnt++;
    m_v[tg] = 1'b1; m_own[tg] = o; m_addr[tg] = a;
  endtask

  task automatic do_req(input logic o, input logic st, input logic [`XLEN-1:0] a,
                        input logic [63:0] d, input MEM_SIZE sz, input int dly,
                        input logic [3:0] tg);
    BUS_COMMAND ec;
    ec = st ? BUS_STORE : BUS_LOAD;
    cl_req_valid[o] = 1'b1; cl_req_store[o] = st; cl_req_addr[o] = a;
    cl_req_data[o] = d; cl_req_size[o] = sz;
    wait_cmd(ec);
    for (int i = 0; i <= dly; i++) begin
      check("cmd", {62'd0, proc2mem_command}, {62'd0, ec});
      check("bus_addr", {32'd0, proc2mem_addr}, {32'd0, a});
      check("bus_size", {62'd0, proc2mem_size}, {62'd0, sz});
      if (st) check("bus_data", proc2mem_data, d);
      check("ack_early", {62'd0, cl_req_ack}, 64'd0);
      mem2proc_response = (i == dly) ? tg : 4'd0;
      tick();
    end
    mem2proc_response = '0;
    check("ack", {62'd0, cl_req_ack}, {62'd0, oh(o)});
    check("cmd_idle", {62'd0, proc2mem_command}, {62'd0, BUS_NONE});
    cl_req_valid[o] = 1'b0;
    if (!st) model_alloc(tg, o, a);
    check("cnt_accept", {59'd0, outstanding_cnt}, 64'(exp_cnt));
    last_owner = o;
  endtask

  task automatic do_ret(input logic [3:0] tg, input logic [63:0] d);
    logic [1:0] exp_rsp = 2'b00;
    mem2proc_tag = tg; mem2proc_data = d;
    if (m_v[tg]) begin
      sb_q.push_back('{owner: m_own[tg], data: d, addr: m_addr[tg]});
      exp_rsp = oh(m_own[tg]);
      m_v[tg] = 1'b0;
      exp_cnt--;
    end else if (tg != 4'd0) begin
      exp_err = 1'b1;
    end
    tick();
    mem2proc_tag = '0;
    check("rsp_valid", {62'd0, cl_rsp_valid}, {62'd0, exp_rsp});
    check("cnt_ret", {59'd0, outstanding_cnt}, 64'(exp_cnt));
    check("err_ret", {63'd0, protocol_error}, {63'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       eo;
    int         idx[2];
    logic [63:0] d5;

    cl_req_valid = '0; cl_req_store = '0; cl_req_addr = '0; cl_req_data = '0;
    cl_req_size[0] = MEM_BYTE; cl_req_size[1] = MEM_BYTE;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 64'h0, MEM_DOUBLE, 3, 4'd5, 1'b1, 64'hDEADBEEF_CAFEF00D};
    vecs[1] = '{1'b1, 1'b0, 32'h140, 64'h0, MEM_WORD,   0, 4'd2, 1'b1, 64'h1111_2222_3333_4444};
    vecs[2] = '{1'b1, 1'b1, 32'h200, 64'h55, MEM_DOUBLE, 1, 4'd7, 1'b0, 64'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h308, 64'hA5A5_5A5A_0F0F_F0F0, MEM_BYTE, 2, 4'd1, 1'b0, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h3FC, 64'h0, MEM_HALF,  0, 4'd15, 1'b1, 64'h0123_4567_89AB_CDEF};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd", {62'd0, proc2mem_command}, {62'd0, BUS_NONE});
    check("rst_addr", {32'd0, proc2mem_addr}, 64'd0);
    check("rst_ack", {62'd0, cl_req_ack}, 64'd0);
    check("rst_rsp", {62'd0, cl_rsp_valid}, 64'd0);
    check("rst_cnt", {59'd0, outstanding_cnt}, 64'd0);
    check("rst_err", {63'd0, protocol_error}, 64'd0);
    reset = 1'b1;
    tick();

    // Single transactions from the vector table
    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].owner, vecs[i].store, vecs[i].addr, vecs[i].data,
             vecs[i].size, vecs[i].delay, vecs[i].tag);
      if (vecs[i].ret) do_ret(vecs[i].tag, vecs[i].rdata);
    end

    // Both clients continuously requesting: grants alternate
    eo = ~last_owner;
    idx[0] = 0; idx[1] = 0;
    for (int c = 0; c < 2; c++) begin
      cl_req_valid[c] = 1'b1; cl_req_store[c] = 1'b0; cl_req_size[c] = MEM_DOUBLE;
      cl_req_addr[c] = 32'h1000 + 32'(c) * 32'h1000;
    end
    for (int k = 0; k < 4; k++) begin
      wait_cmd(BUS_LOAD);
      check("rr_addr", {32'd0, proc2mem_addr},
            {32'd0, 32'h1000 + (eo ? 32'h1000 : 32'h0) + 32'(idx[eo]) * 32'd8});
      mem2proc_response = 4'(k + 1);
      tick();
      mem2proc_response = '0;
      check("rr_ack", {62'd0, cl_req_ack}, {62'd0, oh(eo)});
      model_alloc(4'(k + 1), eo, 32'h1000 + (eo ? 32'h1000 : 32'h0) + 32'(idx[eo]) * 32'd8);
      idx[eo]++;
      if (idx[eo] == 2) cl_req_valid[eo] = 1'b0;
      else cl_req_addr[eo] = 32'h1000 + (eo ? 32'h1000 : 32'h0) + 32'(idx[eo]) * 32'd8;
      eo = ~eo;
    end
    check("rr_cnt", {59'd0, outstanding_cnt}, 64'd4);
    do_ret(4'd3, 64'h3333_0000_0000_0003);
    do_ret(4'd1, 64'h1111_0000_0000_0001);
    do_ret(4'd4, 64'h4444_0000_0000_0004);
    do_ret(4'd2, 64'h2222_0000_0000_0002);

    // Same-cycle return of tag 3 and new load accept with tag 3
    do_req(1'b0, 1'b0, 32'h500, 64'h0, MEM_DOUBLE, 0, 4'd3);
    cl_req_valid[1] = 1'b1; cl_req_store[1] = 1'b0; cl_req_addr[1] = 32'h600;
    cl_req_size[1] = MEM_WORD;
    wait_cmd(BUS_LOAD);
    d5 = 64'hFEED_FACE_0000_0500;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd3; mem2proc_data = d5;
    sb_q.push_back('{owner: 1'b0, data: d5, addr: 32'h500});
    m_v[3] = 1'b0; exp_cnt--;
    tick();
    mem2proc_response = '0; mem2proc_tag = '0; cl_req_valid[1] = 1'b0;
    model_alloc(4'd3, 1'b1, 32'h600);
    check("same_rsp", {62'd0, cl_rsp_valid}, 64'd1);
    check("same_ack", {62'd0, cl_req_ack}, 64'd2);
    check("same_err", {63'd0, protocol_error}, 64'd0);
    check("same_cnt", {59'd0, outstanding_cnt}, 64'(exp_cnt));
    do_ret(4'd3, 64'h0600_0600_0600_0600);

    // Tag 0 ignored, then stray tag 7 from the earlier store
    do_ret(4'd0, 64'hBAD0);
    do_ret(4'd7, 64'hBAD7);

    // Reset in the middle of ISSUE with two loads outstanding
    do_req(1'b0, 1'b0, 32'h700, 64'h0, MEM_DOUBLE, 0, 4'd1);
    do_req(1'b1, 1'b0, 32'h780, 64'h0, MEM_DOUBLE, 0, 4'd2);
    cl_req_valid[0] = 1'b1; cl_req_addr[0] = 32'h7C0;
    wait_cmd(BUS_LOAD);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cmd", {62'd0, proc2mem_command}, {62'd0, BUS_NONE});
    check("mid_rst_addr", {32'd0, proc2mem_addr}, 64'd0);
    check("mid_rst_rdata", cl_rsp_data, 64'd0);
    check("mid_rst_raddr", {32'd0, cl_rsp_addr}, 64'd0);
    check("mid_rst_cnt", {59'd0, outstanding_cnt}, 64'd0);
    check("mid_rst_err", {63'd0, protocol_error}, 64'd0);
    cl_req_valid = '0;
    for (int t = 0; t < 16; t++) m_v[t] = 1'b0;
    exp_cnt = 0; exp_err = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    do_ret(4'd1, 64'hDEAD_0001);

    @(negedge clock);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
